// File: rtl/bisr_pkg.sv
// Shared definitions for the BISR redundancy-analysis stage and the address
// remapper that consumes its repair signatures.
//   - default geometry constants (address width, array size, spare counts)
//   - allocator state encoding
//   - fault log entry layout
package bisr_pkg;

  localparam int BISR_ADDR_WIDTH  = 4;
  localparam int BISR_MAX_ROWS    = 16;
  localparam int BISR_MAX_COLS    = 16;
  localparam int BISR_SPARE_ROWS  = 4;
  localparam int BISR_SPARE_COLS  = 4;
  localparam int BISR_FAULT_DEPTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_MUST_ROW,
    ST_MUST_COL,
    ST_GREEDY,
    ST_DONE,
    ST_FAIL
  } bisr_alloc_state_t;

  typedef struct packed {
    logic                       valid;
    logic [BISR_ADDR_WIDTH-1:0] row;
    logic [BISR_ADDR_WIDTH-1:0] col;
  } fault_entry_t;

endpackage

// File: rtl/bisr_fault_log.sv
// Unique-fault log: a small CAM that holds the distinct (row, col) pairs seen
// in one MBIST run.
//   clk, rst          : clock, synchronous active-high reset
//   clear             : empties the log (new run)
//   lookup_row/col    : address being reported; also the data appended
//   append            : write lookup_row/col into the next free entry
//   hit               : lookup address already present (combinational)
//   full              : all entries in use (combinational)
//   rd_idx / rd_entry : random read port used by the greedy scan
module bisr_fault_log
  import bisr_pkg::*;
#(
  parameter int FAULT_DEPTH = BISR_FAULT_DEPTH,
  localparam int IDX_W = $clog2(FAULT_DEPTH),
  localparam int CNT_W = $clog2(FAULT_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [BISR_ADDR_WIDTH-1:0] lookup_row,
  input  logic [BISR_ADDR_WIDTH-1:0] lookup_col,
  input  logic                       append,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic                       hit,
  output logic                       full,
  output fault_entry_t               rd_entry
);

  fault_entry_t     entries [FAULT_DEPTH];
  logic [CNT_W-1:0] count;

  assign full     = (count == CNT_W'(FAULT_DEPTH));
  assign rd_entry = entries[rd_idx];

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < FAULT_DEPTH; i++) begin
      if (entries[i].valid && entries[i].row == lookup_row &&
          entries[i].col == lookup_col) begin
        hit = 1'b1;
      end
    end
  end

  // Entries fill in order, so count doubles as the write pointer.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      for (int i = 0; i < FAULT_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (append && !full) begin
      entries[count[IDX_W-1:0]] <= '{valid: 1'b1, row: lookup_row, col: lookup_col};
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bisr_repair_alloc.sv
// Redundancy allocator feeding the BISR address remapper. Collects unique
// faulty cells during an MBIST run, then assigns spare rows/columns with a
// must-repair pass (rows, then columns) followed by a greedy pass over the log.
//   clk, rst                : clock, synchronous active-high reset
//   start                   : clear everything and begin collecting
//   fault_valid/row/col     : fault report from the MBIST comparator
//   test_done               : end of MBIST run
//   row/col_repair_sig      : lines to replace (zero while in FAIL)
//   rows_used/cols_used     : spares consumed (zero while in FAIL)
//   busy                    : collecting or analysing
//   repair_done/repair_fail : analysis finished / finished unrepairable
//   overflow                : sticky, more unique faults than log entries
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, waiting for start
// COLLECT   | logging unique faults until test_done
// MUST_ROW  | one row per cycle: repair rows with too many faults for columns
// MUST_COL  | one column per cycle: same test against remaining spare rows
// GREEDY    | one log entry per cycle: cover leftovers, rows first
// DONE      | signatures valid and held until start
// FAIL      | unrepairable or log overflow; signatures forced to zero
module bisr_repair_alloc
  import bisr_pkg::*;
#(
  parameter int ADDR_WIDTH  = BISR_ADDR_WIDTH,
  parameter int MAX_ROWS    = BISR_MAX_ROWS,
  parameter int MAX_COLS    = BISR_MAX_COLS,
  parameter int SPARE_ROWS  = BISR_SPARE_ROWS,
  parameter int SPARE_COLS  = BISR_SPARE_COLS,
  parameter int FAULT_DEPTH = BISR_FAULT_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              fault_valid,
  input  logic [ADDR_WIDTH-1:0]             fault_row,
  input  logic [ADDR_WIDTH-1:0]             fault_col,
  input  logic                              test_done,
  output logic [MAX_ROWS-1:0]               row_repair_sig,
  output logic [MAX_COLS-1:0]               col_repair_sig,
  output logic [$clog2(SPARE_ROWS+1)-1:0]   rows_used,
  output logic [$clog2(SPARE_COLS+1)-1:0]   cols_used,
  output logic                              busy,
  output logic                              repair_done,
  output logic                              repair_fail,
  output logic                              overflow
);

  localparam int RU_W      = $clog2(SPARE_ROWS + 1);
  localparam int CU_W      = $clog2(SPARE_COLS + 1);
  localparam int RC_W      = $clog2(MAX_COLS + 1);
  localparam int CC_W      = $clog2(MAX_ROWS + 1);
  localparam int LOG_IDX_W = $clog2(FAULT_DEPTH);
  localparam int SCAN_W    = $clog2(MAX_ROWS + MAX_COLS + FAULT_DEPTH);

  bisr_alloc_state_t state_q, state_d;

  logic [MAX_ROWS-1:0] row_sig_q;
  logic [MAX_COLS-1:0] col_sig_q;
  logic [RU_W-1:0]     rows_used_q;
  logic [CU_W-1:0]     cols_used_q;
  logic                overflow_q;
  logic [RC_W-1:0]     row_cnt [MAX_ROWS];
  logic [CC_W-1:0]     col_cnt [MAX_COLS];
  logic [SCAN_W-1:0]   scan_idx;

  logic                log_hit, log_full, log_append, overflow_set, fault_in;
  fault_entry_t        log_rd;
  logic [ADDR_WIDTH-1:0] scan_addr, rep_row_idx, rep_col_idx;
  logic                row_need, col_need, greedy_open, scanning;
  logic                rep_row, rep_col;

  // start wins over a coincident fault report.
  assign fault_in     = (state_q == ST_COLLECT) && fault_valid && !start;
  assign log_append   = fault_in && !log_hit && !log_full;
  assign overflow_set = fault_in && !log_hit && log_full;

  assign scan_addr   = scan_idx[ADDR_WIDTH-1:0];
  assign row_need    = int'(row_cnt[scan_addr]) > (SPARE_COLS - int'(cols_used_q));
  assign col_need    = int'(col_cnt[scan_addr]) > (SPARE_ROWS - int'(rows_used_q));
  assign greedy_open = log_rd.valid && !row_sig_q[log_rd.row] && !col_sig_q[log_rd.col];
  assign scanning    = (state_q == ST_MUST_ROW) || (state_q == ST_MUST_COL) ||
                       (state_q == ST_GREEDY);

  bisr_fault_log #(
    .FAULT_DEPTH (FAULT_DEPTH)
  ) u_fault_log (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .lookup_row (fault_row),
    .lookup_col (fault_col),
    .append     (log_append),
    .rd_idx     (scan_idx[LOG_IDX_W-1:0]),
    .hit        (log_hit),
    .full       (log_full),
    .rd_entry   (log_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, plus the repair decision for the line under the scan pointer.
  always_comb begin
    state_d     = state_q;
    rep_row     = 1'b0;
    rep_col     = 1'b0;
    rep_row_idx = '0;
    rep_col_idx = '0;
    if (start) begin
      state_d = ST_COLLECT;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_COLLECT: begin
          if (test_done) begin
            state_d = (overflow_q || overflow_set) ? ST_FAIL : ST_MUST_ROW;
          end
        end
        ST_MUST_ROW: begin
          if (row_need && rows_used_q == RU_W'(SPARE_ROWS)) begin
            state_d = ST_FAIL;
          end else begin
            rep_row     = row_need;
            rep_row_idx = scan_addr;
            if (scan_idx == SCAN_W'(MAX_ROWS - 1)) state_d = ST_MUST_COL;
          end
        end
        ST_MUST_COL: begin
          if (col_need && cols_used_q == CU_W'(SPARE_COLS)) begin
            state_d = ST_FAIL;
          end else begin
            rep_col     = col_need;
            rep_col_idx = scan_addr;
            if (scan_idx == SCAN_W'(MAX_COLS - 1)) state_d = ST_GREEDY;
          end
        end
        ST_GREEDY: begin
          if (greedy_open && rows_used_q == RU_W'(SPARE_ROWS) &&
              cols_used_q == CU_W'(SPARE_COLS)) begin
            state_d = ST_FAIL;
          end else begin
            if (greedy_open) begin
              if (rows_used_q < RU_W'(SPARE_ROWS)) begin
                rep_row     = 1'b1;
                rep_row_idx = log_rd.row;
              end else begin
                rep_col     = 1'b1;
                rep_col_idx = log_rd.col;
              end
            end
            if (scan_idx == SCAN_W'(FAULT_DEPTH - 1)) state_d = ST_DONE;
          end
        end
        ST_DONE: ;
        ST_FAIL: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      row_sig_q   <= '0;
      col_sig_q   <= '0;
      rows_used_q <= '0;
      cols_used_q <= '0;
      overflow_q  <= 1'b0;
      scan_idx    <= '0;
      for (int r = 0; r < MAX_ROWS; r++) row_cnt[r] <= '0;
      for (int c = 0; c < MAX_COLS; c++) col_cnt[c] <= '0;
    end else begin
      if (overflow_set) overflow_q <= 1'b1;
      for (int r = 0; r < MAX_ROWS; r++) begin
        if (log_append && fault_row == ADDR_WIDTH'(r) && row_cnt[r] != RC_W'(MAX_COLS)) begin
          row_cnt[r] <= row_cnt[r] + 1'b1;
        end
      end
      for (int c = 0; c < MAX_COLS; c++) begin
        if (log_append && fault_col == ADDR_WIDTH'(c) && col_cnt[c] != CC_W'(MAX_ROWS)) begin
          col_cnt[c] <= col_cnt[c] + 1'b1;
        end
      end
      // Each scan phase starts its pointer at zero.
      if (state_d != state_q) begin
        scan_idx <= '0;
      end else if (scanning) begin
        scan_idx <= scan_idx + 1'b1;
      end
      if (rep_row) begin
        row_sig_q[rep_row_idx] <= 1'b1;
        rows_used_q            <= rows_used_q + 1'b1;
      end
      if (rep_col) begin
        col_sig_q[rep_col_idx] <= 1'b1;
        cols_used_q            <= cols_used_q + 1'b1;
      end
    end
  end

  // In FAIL the remapper must see no repairs so addresses pass through.
  always_comb begin
    busy           = 1'b0;
    repair_done    = 1'b0;
    repair_fail    = 1'b0;
    overflow       = overflow_q;
    row_repair_sig = row_sig_q;
    col_repair_sig = col_sig_q;
    rows_used      = rows_used_q;
    cols_used      = cols_used_q;
    case (state_q)
      ST_COLLECT, ST_MUST_ROW, ST_MUST_COL, ST_GREEDY: busy = 1'b1;
      ST_DONE: repair_done = 1'b1;
      ST_FAIL: begin
        repair_done    = 1'b1;
        repair_fail    = 1'b1;
        row_repair_sig = '0;
        col_repair_sig = '0;
        rows_used      = '0;
        cols_used      = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/bisr_repair_alloc.md
Name: bisr_repair_alloc

Overview:
- Redundancy-analysis stage directly upstream of the BISR address remapper.
- Logs unique faulty (row, col) cells reported by the MBIST comparator during a test run.
- After the test, allocates spare rows/columns by must-repair analysis followed by a greedy pass.
- Drives row_repair_sig/col_repair_sig into the remapper; guarantees each signature's popcount never exceeds its spare count, so remapper spare indexing stays in range.

Parameters:
ADDR_WIDTH, 4, logical row/col address width
MAX_ROWS, 16, logical rows
MAX_COLS, 16, logical columns
SPARE_ROWS, 4, spare rows available
SPARE_COLS, 4, spare columns available
FAULT_DEPTH, 8, unique fault log entries

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start  input  1  pulse: clear state, begin collecting
fault_valid  input  1  fault report strobe
fault_row  input  ADDR_WIDTH  faulty row
fault_col  input  ADDR_WIDTH  faulty column
test_done  input  1  pulse: MBIST run finished
row_repair_sig  output  MAX_ROWS  rows to replace
col_repair_sig  output  MAX_COLS  columns to replace
rows_used  output  $clog2(SPARE_ROWS+1)  spare rows allocated
cols_used  output  $clog2(SPARE_COLS+1)  spare columns allocated
busy  output  1  high in COLLECT/MUST_ROW/MUST_COL/GREEDY
repair_done  output  1  level, high in DONE or FAIL
repair_fail  output  1  level, high in FAIL
overflow  output  1  sticky, log overflowed this run

Behaviour:
- Reset state: IDLE. All outputs 0, log empty, per-row/per-col fault counters 0.
- States: IDLE, COLLECT, MUST_ROW, MUST_COL, GREEDY, DONE, FAIL.
- start sampled in any state:
  - clears log, counters, signatures, used counts, overflow;
  - next state COLLECT;
  - has priority over all other inputs, including mid-analysis.
- COLLECT, on each fault_valid:
  - (row,col) already in log → ignore;
  - log full → set overflow;
  - else append entry, increment row_cnt[row] and col_cnt[col] (saturating, width $clog2(MAX+1)).
- COLLECT, on test_done:
  - fault_valid in the same cycle is logged first;
  - overflow set (including set this cycle) → FAIL; else → MUST_ROW.
- fault_valid/test_done outside COLLECT are ignored.
- MUST_ROW: scans r = 0..MAX_ROWS-1, one per cycle.
  - If row_cnt[r] > SPARE_COLS − cols_used: set row_repair_sig[r], rows_used++.
  - If rows_used already equals SPARE_ROWS when a repair is needed → FAIL next cycle.
- MUST_COL: scans c = 0..MAX_COLS-1, one per cycle.
  - Threshold is col_cnt[c] > SPARE_ROWS − rows_used.
  - Symmetric fail rule.
- GREEDY: scans log entries i = 0..FAULT_DEPTH-1, one per cycle; invalid entries are skipped but still take their cycle.
  - Entry covered if its row sig or col sig is already set.
  - Otherwise repair its row if rows_used < SPARE_ROWS, else its column if cols_used < SPARE_COLS, else → FAIL.
- Latency: test_done sampled at cycle T → repair_done high at T+1+MAX_ROWS+MAX_COLS+FAULT_DEPTH (T+41 at defaults) when no fail occurs.
- Overflow path: FAIL at T+1.
- DONE: signatures and used counts held stable until start.
- FAIL: signatures and used counts forced to 0 (remapper passes addresses through); overflow keeps its value.
- Downstream consumes signatures only while repair_done=1 and repair_fail=0.
- Zero faults: no repairs, DONE at the nominal latency.

Decomposition:
- Package bisr_pkg:
  - state enum bisr_alloc_state_t;
  - struct fault_entry_t {valid, row, col};
  - default-parameter constants shared with the remapper.
- Sub-module bisr_fault_log:
  - FAULT_DEPTH-entry CAM log with combinational hit/full and append;
  - read port indexed by the GREEDY scan pointer.

Test Plan:
- rst held 2 cycles → all outputs 0, busy=0; start → busy=1 next cycle.
- start; faults (3,5), (3,5), (9,2); test_done → duplicate dropped; row_repair_sig=0x0208, col_repair_sig=0, rows_used=2, repair_done at T+41, repair_fail=0.
- Faults (7,0)..(7,4) → row 7 repaired in MUST_ROW; row_repair_sig=0x0080, col_repair_sig=0.
- Faults (0,0), (1,1), (2,2), (3,3), (4,4) → row_repair_sig=0x000F, col_repair_sig=0x0010, rows_used=4, cols_used=1.
- 9 unique faults → overflow=1; repair_fail and repair_done at T+1; both signatures 0.
- start mid-COLLECT clears log; fault_valid coincident with test_done is logged; start during GREEDY aborts to COLLECT with signatures cleared.
